// File: rtl/sig_mixer_if.sv
// sig_mixer_if: bundles the mixer's strobe/config/sample inputs and its
// result/status outputs.
//   master modport: the sample source / controller (drives strobe, ch_en,
//                   gain, sig_in; reads sig, sig_valid, clip, busy, overrun)
//   slave modport : the sig_mixer core
// Optional feature macro: SIG_MIXER_NOISE_EN adds the 1-bit noise_en input.
interface sig_mixer_if #(
  parameter int N_CH   = 5,
  parameter int W      = 16,
  parameter int GAIN_W = 4
);
  logic                     strobe;
  logic [N_CH-1:0]          ch_en;
  logic [N_CH*GAIN_W-1:0]   gain;
  logic [N_CH*W-1:0]        sig_in;
`ifdef SIG_MIXER_NOISE_EN
  logic                     noise_en;
`endif
  logic [W-1:0]             sig;
  logic                     sig_valid;
  logic                     clip;
  logic                     busy;
  logic                     overrun;

  modport master (
`ifdef SIG_MIXER_NOISE_EN
    output noise_en,
`endif
    output strobe, ch_en, gain, sig_in,
    input  sig, sig_valid, clip, busy, overrun
  );

  modport slave (
`ifdef SIG_MIXER_NOISE_EN
    input  noise_en,
`endif
    input  strobe, ch_en, gain, sig_in,
    output sig, sig_valid, clip, busy, overrun
  );
endinterface

// File: rtl/sig_mixer.sv
// sig_mixer: time-multiplexed N_CH-channel waveform mixer.
// On a strobe in IDLE the channel samples, gains and enables are snapshotted;
// one channel per clock is scaled by its Q1.(GAIN_W-1) gain and accumulated;
// the sum is then saturated to W bits and presented with a one-cycle valid.
// Ports:
//   clk    - sample-domain clock
//   rst_n  - asynchronous active-low reset
//   bus    - sig_mixer_if.slave: strobe, ch_en, gain, sig_in in;
//            sig, sig_valid, clip, busy, overrun out (all registered)
// Optional feature macro: SIG_MIXER_NOISE_EN adds a 16-bit Fibonacci LFSR
// noise source mixed in at unity gain as an extra accumulate step.
module sig_mixer #(
  parameter int N_CH   = 5,
  parameter int W      = 16,
  parameter int GAIN_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  sig_mixer_if.slave  bus
);

  // Sized so N_CH terms of max sample * max gain cannot wrap.
  localparam int ACC_W = W + GAIN_W + $clog2(N_CH + 1);
`ifdef SIG_MIXER_NOISE_EN
  localparam int STEPS = N_CH + 1;
`else
  localparam int STEPS = N_CH;
`endif
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = {{(ACC_W-W){1'b0}}, {W{1'b1}}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  // Sample times gain, dropping the GAIN_W-1 fractional bits.
  function automatic logic [ACC_W-1:0] scaled(input logic [W-1:0] s,
                                              input logic [GAIN_W-1:0] g);
    logic [W+GAIN_W-1:0] prod;
    prod   = {{GAIN_W{1'b0}}, s} * {{W{1'b0}}, g};
    scaled = ACC_W'(prod >> (GAIN_W - 1));
  endfunction

  logic [1:0]             state_q,    state_d;
  logic [IDX_W-1:0]       idx_q,      idx_d;
  logic [ACC_W-1:0]       acc_q,      acc_d;
  logic [N_CH*W-1:0]      snap_sig_q, snap_sig_d;
  logic [N_CH*GAIN_W-1:0] snap_gain_q, snap_gain_d;
  logic [N_CH-1:0]        snap_en_q,  snap_en_d;
  logic [W-1:0]           sig_q,      sig_d;
  logic                   sig_valid_q, sig_valid_d;
  logic                   clip_q,     clip_d;
  logic                   busy_q,     busy_d;
  logic                   overrun_q,  overrun_d;
  logic [ACC_W-1:0]       step_s;

`ifdef SIG_MIXER_NOISE_EN
  // Fibonacci LFSR, taps 15/14/12/3, feedback shifted in at the LSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    lfsr_next = {cur[14:0], cur[15] ^ cur[14] ^ cur[12] ^ cur[3]};
  endfunction

  logic [15:0] lfsr_q,       lfsr_d;
  logic        snap_noise_q, snap_noise_d;
`endif

  // Contribution of the current accumulate step (zero for disabled channels).
  always_comb begin
    step_s = {ACC_W{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      if ((idx_q == IDX_W'(i)) && snap_en_q[i]) begin
        step_s = scaled(snap_sig_q[i*W +: W], snap_gain_q[i*GAIN_W +: GAIN_W]);
      end else begin
        step_s = step_s;
      end
    end
`ifdef SIG_MIXER_NOISE_EN
    // LFSR was advanced on the accepting strobe and holds for the whole mix.
    if ((idx_q == IDX_W'(N_CH)) && snap_noise_q) begin
      step_s = ACC_W'(lfsr_q);
    end else begin
      step_s = step_s;
    end
`endif
  end

  // Next-state logic for the IDLE -> ACC -> OUT mix sequence.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    snap_sig_d  = snap_sig_q;
    snap_gain_d = snap_gain_q;
    snap_en_d   = snap_en_q;
    sig_d       = sig_q;
    clip_d      = clip_q;
    sig_valid_d = 1'b0;
    // A strobe in ACC or OUT is dropped and flagged one cycle later.
    overrun_d   = bus.strobe && (state_q != IDLE);
`ifdef SIG_MIXER_NOISE_EN
    lfsr_d       = lfsr_q;
    snap_noise_d = snap_noise_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.strobe) begin
          snap_sig_d  = bus.sig_in;
          snap_gain_d = bus.gain;
          snap_en_d   = bus.ch_en;
          acc_d       = {ACC_W{1'b0}};
          idx_d       = {IDX_W{1'b0}};
          state_d     = ACC;
`ifdef SIG_MIXER_NOISE_EN
          lfsr_d       = lfsr_next(lfsr_q);
          snap_noise_d = bus.noise_en;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        acc_d = acc_q + step_s;
        if (idx_q == LAST_IDX) begin
          state_d = OUT;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      OUT: begin
        if (acc_q > SAT_MAX) begin
          sig_d  = SAT_MAX[W-1:0];
          clip_d = 1'b1;
        end else begin
          sig_d  = acc_q[W-1:0];
          clip_d = 1'b0;
        end
        sig_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any mix in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= {IDX_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      snap_sig_q  <= {(N_CH*W){1'b0}};
      snap_gain_q <= {(N_CH*GAIN_W){1'b0}};
      snap_en_q   <= {N_CH{1'b0}};
      sig_q       <= {W{1'b0}};
      sig_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SIG_MIXER_NOISE_EN
      lfsr_q       <= 16'd773;
      snap_noise_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      snap_sig_q  <= snap_sig_d;
      snap_gain_q <= snap_gain_d;
      snap_en_q   <= snap_en_d;
      sig_q       <= sig_d;
      sig_valid_q <= sig_valid_d;
      clip_q      <= clip_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
`ifdef SIG_MIXER_NOISE_EN
      lfsr_q       <= lfsr_d;
      snap_noise_q <= snap_noise_d;
`endif
    end
  end

  assign bus.sig       = sig_q;
  assign bus.sig_valid = sig_valid_q;
  assign bus.clip      = clip_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_sig_mixer.sv
// tb_sig_mixer: self-checking bench for sig_mixer. A cycle-level behavioural
// model (whole-mix sum computed at the accepting strobe, then a countdown)
// predicts every output each cycle; directed scenarios pin literal values.
module tb_sig_mixer;
  localparam int N_CH   = 5;
  localparam int W      = 16;
  localparam int GAIN_W = 4;
`ifdef SIG_MIXER_NOISE_EN
  localparam int LAT = N_CH + 2;
`else
  localparam int LAT = N_CH + 1;
`endif
  localparam longint MAXV = (64'd1 << W) - 64'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sig_mixer_if #(.N_CH(N_CH), .W(W), .GAIN_W(GAIN_W)) bus ();
  sig_mixer #(.N_CH(N_CH), .W(W), .GAIN_W(GAIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          busy_left;
  logic [W-1:0] m_sig, pend_sig;
  logic        m_clip, pend_clip, m_valid, m_over;
  logic [15:0] m_lfsr;

  initial begin
    busy_left = 0; m_sig = '0; m_clip = 1'b0; m_valid = 1'b0; m_over = 1'b0;
    pend_sig = '0; pend_clip = 1'b0; m_lfsr = 16'd773;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        busy_left = 0; m_sig = '0; m_clip = 1'b0; m_valid = 1'b0; m_over = 1'b0;
        m_lfsr = 16'd773;
      end else begin
        m_valid = 1'b0;
        m_over  = 1'b0;
        if (busy_left > 0) begin
          m_over = bus.strobe;
          busy_left--;
          if (busy_left == 0) begin
            m_valid = 1'b1;
            m_sig   = pend_sig;
            m_clip  = pend_clip;
          end
        end else if (bus.strobe) begin
          longint sum;
          sum = 0;
          for (int i = 0; i < N_CH; i++) begin
            if (bus.ch_en[i])
              sum += (longint'(bus.sig_in[i*W +: W]) *
                      longint'(bus.gain[i*GAIN_W +: GAIN_W])) / (64'd1 << (GAIN_W-1));
          end
`ifdef SIG_MIXER_NOISE_EN
          m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3]};
          if (bus.noise_en) sum += longint'(m_lfsr);
`endif
          pend_clip = (sum > MAXV);
          pend_sig  = pend_clip ? W'(MAXV) : W'(sum);
          busy_left = LAT;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        chk("sig_valid", 64'(bus.sig_valid), 64'(m_valid));
        chk("busy", 64'(bus.busy), 64'(busy_left > 0));
        chk("overrun", 64'(bus.overrun), 64'(m_over));
        chk("sig", 64'(bus.sig), 64'(m_sig));
        if (m_valid) chk("clip", 64'(bus.clip), 64'(m_clip));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ch(input int i, input int s, input int g);
    bus.sig_in[i*W +: W]         = W'(s);
    bus.gain[i*GAIN_W +: GAIN_W] = GAIN_W'(g);
  endtask

  task automatic clear_inputs();
    bus.strobe = 1'b0;
    bus.ch_en  = '0;
    bus.gain   = '0;
    bus.sig_in = '0;
`ifdef SIG_MIXER_NOISE_EN
    bus.noise_en = 1'b0;
`endif
  endtask

  // Strobe with the current inputs, wait (bounded) for sig_valid, pin results.
  task automatic run_mix(input string nm, input int exp_sig, input bit exp_clip);
    int lat;
    @(negedge clk);
    bus.strobe = 1'b1;
    @(posedge clk);
    #1 bus.strobe = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.sig_valid) break;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(LAT));
    chk({nm, "_sig"}, 64'(bus.sig), 64'(exp_sig));
    chk({nm, "_clip"}, 64'(bus.clip), 64'(exp_clip));
    @(negedge clk);
  endtask

  initial begin
    int n_ov;
    int n_v;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("rst_sig", 64'(bus.sig), 64'd0);
    chk("rst_valid", 64'(bus.sig_valid), 64'd0);
    chk("rst_clip", 64'(bus.clip), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_overrun", 64'(bus.overrun), 64'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Two channels at unity gain.
    bus.ch_en = 5'b00011;
    for (int i = 0; i < N_CH; i++) set_ch(i, 0, 8);
    set_ch(0, 1000, 8);
    set_ch(1, 2000, 8);
    run_mix("basic", 3000, 1'b0);

    // Gain scaling.
    bus.ch_en = 5'b00001;
    set_ch(0, 1000, 4);
    run_mix("gain4", 500, 1'b0);
    set_ch(0, 1000, 15);
    run_mix("gain15", 1875, 1'b0);

    // Saturation, then all channels disabled.
    bus.ch_en = 5'b11111;
    for (int i = 0; i < N_CH; i++) set_ch(i, 65535, 15);
    run_mix("sat", 65535, 1'b1);
    bus.ch_en = 5'b00000;
    run_mix("zero", 0, 1'b0);

    // Overrun: second strobe 3 clocks after the first.
    bus.ch_en = 5'b00001;
    set_ch(0, 100, 8);
    n_ov = 0; n_v = 0;
    @(negedge clk);
    bus.strobe = 1'b1;
    @(negedge clk);
    bus.strobe = 1'b0;
    set_ch(0, 7, 8);
    @(negedge clk);
    @(negedge clk);
    bus.strobe = 1'b1;
    @(negedge clk);
    bus.strobe = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.overrun) n_ov++;
      if (bus.sig_valid) n_v++;
      @(negedge clk);
    end
    chk("overrun_pulses", 64'(n_ov), 64'd1);
    chk("overrun_valids", 64'(n_v), 64'd1);
    chk("overrun_sig", 64'(bus.sig), 64'd100);

    // Reset mid-mix at the third ACC clock.
    bus.ch_en = 5'b00001;
    set_ch(0, 1234, 8);
    @(negedge clk);
    bus.strobe = 1'b1;
    @(posedge clk);
    #1 bus.strobe = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_sig", 64'(bus.sig), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_valid", 64'(bus.sig_valid), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_v = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.sig_valid) n_v++;
    end
    chk("abort_no_valid", 64'(n_v), 64'd0);
    bus.ch_en = 5'b00011;
    set_ch(0, 1000, 8);
    set_ch(1, 2000, 8);
    run_mix("post_abort", 3000, 1'b0);

    // Randomised traffic; inputs also change mid-mix.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.ch_en = N_CH'($urandom);
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 3) == 0) set_ch(i, 65535, $urandom_range(0, 15));
        else set_ch(i, int'($urandom_range(0, 65535)), $urandom_range(0, 15));
      end
`ifdef SIG_MIXER_NOISE_EN
      bus.noise_en = 1'($urandom);
`endif
      bus.strobe = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    bus.strobe = 1'b0;
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
